// File: rtl/sar_search_10_pkg.sv
// Shared types and constants for the 10-bit successive-approximation search engine
// and the magnitude comparator it queries.
package sar_search_10_pkg;

  localparam int ALU_W  = 10;

  // Bit positions inside the 3-bit one-hot comparator result
  localparam int CMP_EQ = 0;
  localparam int CMP_GT = 1;
  localparam int CMP_LT = 2;

  typedef enum logic [1:0] {
    SAR_IDLE,
    SAR_SEARCH,
    SAR_DONE
  } sar_state_t;

endpackage

// File: rtl/sar_search_10_if.sv
// Query/result bundle between the SAR search engine (slave) and whoever
// supplies start and the comparator verdict (master).
interface sar_search_10_if
  import sar_search_10_pkg::*;
#(
  parameter int WIDTH = ALU_W
);

  logic             start;
  logic [2:0]       cmp_in;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, cmp_in,
    input  trial, result, busy, done, err
  );

  modport slave (
    input  start, cmp_in,
    output trial, result, busy, done, err
  );

endinterface

// File: rtl/sar_search_10_comp.sv
// Combinational magnitude comparator producing the one-hot eq/gt/lt verdict
// consumed by the SAR search engine (a = trial, b = target).
module comp_10
  import sar_search_10_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [2:0]       cmp_o
);

  always_comb begin
    cmp_o         = '0;
    cmp_o[CMP_EQ] = (a_i == b_i);
    cmp_o[CMP_GT] = (a_i >  b_i);
    cmp_o[CMP_LT] = (a_i <  b_i);
  end

endmodule

// File: rtl/sar_search_10_wrap.sv
// Integration wrapper: SAR search engine closed around comp_10 so that only the
// target value needs to be supplied from outside.
module sar_cmp_top
  import sar_search_10_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] trial_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  sar_search_10_if #(.WIDTH(WIDTH)) sarBus ();

  assign sarBus.start = start_i;

  comp_10 #(.WIDTH(WIDTH)) u_comp (
    .a_i   (sarBus.trial),
    .b_i   (target_i),
    .cmp_o (sarBus.cmp_in)
  );

  sar_search_10 #(.WIDTH(WIDTH)) u_sar (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sarBus)
  );

  assign trial_o  = sarBus.trial;
  assign result_o = sarBus.result;
  assign busy_o   = sarBus.busy;
  assign done_o   = sarBus.done;
  assign err_o    = sarBus.err;

endmodule

// File: rtl/sar_search_10.sv
// Successive-approximation search: resolves an unknown target one bit per cycle, MSB first.
// Optional macro SAR_EARLY_EXIT_EN finishes the search as soon as the comparator reports eq.
module sar_search_10
  import sar_search_10_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sar_search_10_if.slave bus
);

  sar_state_t       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  logic             cmpValid;
  logic [WIDTH-1:0] bitMask;
  logic [WIDTH-1:0] stepTrial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SAR_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  // bitMask selects the bit under test; stepTrial is the trial with that bit resolved
  assign cmpValid  = $onehot(bus.cmp_in);
  assign bitMask   = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
  assign stepTrial = bus.cmp_in[CMP_GT] ? (trial_q & ~bitMask) : trial_q;

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    err_d    = err_q;

    unique case (state_q)
      SAR_IDLE: begin
        if (bus.start) begin
          state_d = SAR_SEARCH;
          trial_d = {1'b1, {(WIDTH-1){1'b0}}};
          idx_d   = CNT_W'(WIDTH - 1);
          err_d   = 1'b0;
        end
      end

      SAR_SEARCH: begin
        if (!cmpValid) begin
          err_d    = 1'b1;
          result_d = trial_q & ~bitMask;
          state_d  = SAR_DONE;
`ifdef SAR_EARLY_EXIT_EN
        end else if (bus.cmp_in[CMP_EQ]) begin
          result_d = trial_q;
          state_d  = SAR_DONE;
`endif
        end else if (idx_q != '0) begin
          trial_d = stepTrial | (bitMask >> 1);
          idx_d   = idx_q - CNT_W'(1);
        end else begin
          trial_d  = stepTrial;
          result_d = stepTrial;
          state_d  = SAR_DONE;
        end
      end

      SAR_DONE: begin
        state_d = SAR_IDLE;
      end

      default: begin
        state_d = SAR_IDLE;
      end
    endcase
  end

  assign bus.trial  = trial_q;
  assign bus.result = result_q;
  assign bus.busy   = (state_q == SAR_SEARCH);
  assign bus.done   = (state_q == SAR_DONE);
  assign bus.err    = err_q;

endmodule
